// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one finished unit per cycle and broadcasts it.
// gnt is combinational with req; the bus shows the result one cycle later. No backpressure on the bus.
module cdb_arbiter #(
    parameter int                N      = 4,
    parameter int                TAG_W  = 8,
    parameter int                DATA_W = 32,
    parameter logic [TAG_W-1:0]  NOTAG  = 8'b01111111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*TAG_W-1:0]     req_tag,
    input  logic [N*DATA_W-1:0]    req_data,
    input  logic                   flush,
    output logic [N-1:0]           gnt,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_data,
    output logic [$clog2(N)-1:0]   cdb_src,
    output logic                   err
);

    localparam int SW = $clog2(N);

    logic [SW-1:0]     ptr;
    logic [SW-1:0]     win_idx;
    logic              win_vld;
    logic              take;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [SW-1:0]     ptr_next;

    // Search from ptr upward with wrap; the first requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_vld && req[(int'(ptr) + k) % N]) begin
                win_vld = 1'b1;
                win_idx = SW'((int'(ptr) + k) % N);
            end
        end
    end

    assign win_tag  = req_tag[int'(win_idx)*TAG_W +: TAG_W];
    assign win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign ptr_next = SW'((int'(win_idx) + 1) % N);
    assign take     = win_vld && !flush && !rst;

    always_comb begin
        gnt = '0;
        if (take) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // A NOTAG winner is still consumed and rotates priority, but never reaches the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= NOTAG;
            cdb_data  <= '0;
            cdb_src   <= '0;
            err       <= 1'b0;
        end else begin
            cdb_valid <= 1'b0;
            if (take) begin
                ptr       <= ptr_next;
                cdb_tag   <= win_tag;
                cdb_data  <= win_data;
                cdb_src   <= win_idx;
                cdb_valid <= (win_tag != NOTAG);
                if (win_tag == NOTAG) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It sits between the functional units (load, add, mul, mv) and the reservation station / register-file tag snoop. Each cycle it grants at most one finished unit, using round-robin priority, and registers that unit's tag and result onto the single broadcast bus. Waiting reservation-station entries and the register status table (ready marker `8'b01111111`) wake up from that bus.

## Interface
Parameters:
- `N`, 4: number of requesting functional units. Index 0=lw, 1=add, 2=mul, 3=mv.
- `TAG_W`, 8: producer tag width. Matches `UNIT_SIZE`.
- `DATA_W`, 32: result width. Matches `WORD_SIZE`.
- `NOTAG`, `8'b01111111`: reserved "value ready / no producer" tag.

Ports:
- `clk`  in  1  single clock, posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  unit i holds a finished result. Held high until granted.
- `req_tag`  in  N*TAG_W  tag of unit i, in slice [i*TAG_W +: TAG_W].
- `req_data`  in  N*DATA_W  result of unit i, in slice [i*DATA_W +: DATA_W].
- `flush`  in  1  squash: no grant this cycle, and the next bus cycle is invalid.
- `gnt`  out  N  one-hot or zero. Combinational, same cycle as `req`.
- `cdb_valid`  out  1  broadcast valid. Registered.
- `cdb_tag`  out  TAG_W  broadcast tag. Registered.
- `cdb_data`  out  DATA_W  broadcast value. Registered.
- `cdb_src`  out  clog2(N)  index of the granted unit. Registered.
- `err`  out  1  sticky flag: a unit requested with tag == `NOTAG`.

## Operation
- Round-robin pointer `ptr` (clog2(N) bits) names the highest-priority index.
- Search order is ptr, ptr+1, …, ptr+N-1, mod N. The first index with `req` high wins.
- After a grant to index i, `ptr` becomes (i+1) mod N. With no grant, `ptr` is unchanged.
- `gnt[i]`=1 only for the winner, and only when `flush`=0 and `rst`=0.
- Requester handshake: unit i treats `gnt[i]` high at a posedge as consumed.
  - It then drops `req` or presents a new result in the next cycle.
  - An un-granted `req` stays high with stable tag and data.
- Capture on a grant to index i:
  - `cdb_tag`<=tag_i, `cdb_data`<=data_i, `cdb_src`<=i.
  - `cdb_valid`<=1, unless tag_i == `NOTAG`.
- Winner with tag == `NOTAG`:
  - It is still granted, so it is consumed and `ptr` still advances.
  - `cdb_valid`<=0 and `err`<=1.
  - Tag and data are still captured, for debug only.
- No winner: `cdb_valid`<=0. `cdb_tag`, `cdb_data` and `cdb_src` hold their last values.
- `flush`=1 in a given cycle:
  - `gnt`=0 and `cdb_valid`<=0.
  - `ptr` and `err` are unchanged.
  - Pending `req` lines are not consumed. Units discard their own state on `flush`.
- Fairness: a continuously requesting unit is granted within N cycles of raising `req` in any non-flush window.
- `err` clears only on `rst`.

## Timing
- Reset (`rst` high at a posedge):
  - `cdb_valid`=0, `cdb_tag`=`NOTAG`, `cdb_data`=0, `cdb_src`=0, `err`=0, `ptr`=0.
  - `gnt`=0 while `rst` is high.
- Latency: `req` high in cycle t gives `gnt` in cycle t (combinational), and the bus shows the result in cycle t+1.
- Throughput: one broadcast per cycle.
- Back-to-back grants to the same unit need it to be the only requester. Otherwise rotation moves priority on.
- Simultaneous `rst` and `flush`: reset wins.
- Reset mid-operation: an in-flight bus cycle is dropped, with `cdb_valid`=0 next cycle and no replay.
- `gnt` has no dependence on the registered outputs, so there is no combinational loop through `cdb_*`.

## Test plan
- Single request, no contention:
  - Stimulus: after reset, `req`=4'b0010 with tag 8'h05 and data 32'd42.
  - Response: `gnt`=4'b0010 in the same cycle.
  - Next cycle: `cdb_valid`=1, `cdb_tag`=8'h05, `cdb_data`=42, `cdb_src`=1.
- Full contention rotation:
  - Stimulus: `req`=4'b1111 held for 4 cycles from reset, each unit dropping `req` on its grant.
  - Response: grants 0,1,2,3 in order, then 4 consecutive valid broadcasts carrying the matching tags.
- Pointer advance:
  - Stimulus: grant to 2, then `req`=4'b1001.
  - Response: grant 3 first, then 0.
- Flush:
  - Stimulus: `req`=4'b0100 with `flush`=1.
  - Response: `gnt`=0, `cdb_valid`=0 next cycle, `ptr` unchanged.
  - Next cycle, with `flush`=0: unit 2 is granted.
- Reserved tag:
  - Stimulus: unit 3 requests with tag 8'h7F.
  - Response: `gnt[3]`=1, `cdb_valid`=0 next cycle, `err`=1 and staying high until `rst`.
- Reset mid-stream:
  - Stimulus: assert `rst` during the contention sequence.
  - Response: next cycle `cdb_valid`=0, `cdb_tag`=8'h7F, `err`=0.
  - The first post-reset grant goes to the lowest requesting index.
